router_input_channel: RTL and testbench
=======================================

# router_input_channel

Receiving end of the RTS/DCTS link into one router input port, the counterpart of the output-side arbiter. It accepts flits from the upstream router's RTS/DCTS handshake into a small FIFO. It decodes the destination of each header flit with XY routing and holds a one-hot request toward the five output arbiters for the whole packet (wormhole). It pops one flit per arbiter grant.

## Interface
- DATA_WIDTH, 32: flit width.
- DEPTH, 4: FIFO entries (power of two, ≥2).
- ADDR_W, 2: bits per X/Y coordinate.
- CUR_X, 0: this router's X coordinate.
- CUR_Y, 0: this router's Y coordinate.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the clk edge).
- RX  in  DATA_WIDTH  incoming flit, valid while RTS high.
- RTS  in  1  upstream request-to-send.
- DCTS  out  1  clear-to-send pulse to upstream.
- Grant_N, Grant_E, Grant_W, Grant_S, Grant_L  in  1 each  grants from output arbiters.
- Req_N, Req_E, Req_W, Req_S, Req_L  out  1 each  one-hot output request.
- Data_out  out  DATA_WIDTH  FIFO head flit.
- empty  out  1  FIFO empty.
- err  out  1  sticky parity error.

## Operation
- Flit type is RX[DATA_WIDTH-1:DATA_WIDTH-2]: 01 header, 10 body, 11 tail; 00 is treated as body.
- Header destination: X = flit[2*ADDR_W-1:ADDR_W], Y = flit[ADDR_W-1:0].
- Handshake (registered DCTS):
  - DCTS_next = RTS & !DCTS & (count < DEPTH).
  - Write happens when RTS & DCTS.
  - DCTS is high for exactly one cycle per flit. Upstream holds RTS and RX stable until it samples DCTS.
- Fullness: count < DEPTH is checked against the current count. A pop in the same cycle does not permit raising DCTS.
- FIFO: circular, read/write pointers wrap modulo DEPTH, count width clog2(DEPTH)+1.
  - Simultaneous write and pop leaves count unchanged.
  - Data_out = mem[rd_ptr], undefined-but-stable when empty.
- Route FSM has two states, IDLE and ROUTED:
  - IDLE with head = header and !empty: route_reg <= XY(head), go to ROUTED.
  - IDLE with a non-header at head: pop is blocked and no request is made. The flit stays until reset.
  - ROUTED: Req_* = route_reg & !empty.
  - Pop of a tail flit: go to IDLE.
- XY route, in priority order:
  - dest_x > CUR_X: E.
  - dest_x < CUR_X: W.
  - dest_y > CUR_Y: S.
  - dest_y < CUR_Y: N.
  - Otherwise: L.
- Pop condition: ROUTED & !empty & (grant on the requested direction). Grants on unrequested directions, or while empty, are ignored.

## Timing
- Reset values: DCTS=0, Req_*=0, empty=1, err=0, count=0, pointers=0, FSM=IDLE, route_reg=0.
- Reset mid-packet discards FIFO contents and any in-flight handshake. DCTS goes to 0 the cycle after the reset edge.
- Accept latency:
  - RTS rises at cycle t; DCTS=1 at t+1; write at the t+1 edge.
  - Earliest next DCTS is t+3, after upstream drops RTS for one cycle.
- Header written at edge e: empty=0 after e; route latched at e+1; Req_* high after e+1.
- Grant at cycle g: pop at edge g. Next head is visible after g; Req_* drops after g if that pop emptied the FIFO or popped the tail.
- Back-to-back packets: after a tail pop, the next header routes one cycle later (IDLE decode cycle).

## Configuration
- ROUTER_PARITY_CHECK_EN defined:
  - Bit DATA_WIDTH-3 is even parity over the whole flit.
  - On each write with odd total parity, err is set sticky until reset. The flit is still stored.
- Not defined: the bit is payload, err is tied to 0, and no parity logic is generated.

## Structure
- Shared package router_pkg holds:
  - The flit-type enum (FLIT_HEADER=2'b01, FLIT_BODY=2'b10, FLIT_TAIL=2'b11).
  - The direction index constants (DIR_N, DIR_E, DIR_W, DIR_S, DIR_L) and a 5-bit one-hot direction typedef.
  - The route FSM state enum.
- One sub-module, router_fifo: parameterized circular buffer with push, pop, count, empty and full.
- The handshake, XY decode and FSM stay in router_input_channel.

## Test plan
- CUR=(1,1), send header dest (3,1), body, tail, with Grant_E following Req_E -> Req_E=1 only; three pops; Req_E=0 after the tail pop; FSM returns to IDLE.
- Destinations (1,0), (1,2), (0,1), (1,1) -> Req_N, Req_S, Req_W, Req_L respectively.
- DEPTH=4, RTS held, no grants -> exactly 4 DCTS pulses, spaced at least 2 cycles apart; no fifth DCTS. One grant -> fifth DCTS within 2 cycles.
- Grant_W while Req_E is active -> no pop, count unchanged; Grant while empty -> no change.
- rst=0 with 3 flits stored and DCTS high -> next cycle empty=1, DCTS=0, Req_*=0; a new header then routes normally.
- With ROUTER_PARITY_CHECK_EN, inject a flit with a flipped parity bit -> err=1 the cycle after the write, and it stays 1 until reset. Without the macro, err stays 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types for the router slice: flit types, output directions and
// the input-channel route FSM states.
package router_pkg;

  typedef enum logic [1:0] {
    FLIT_HEADER = 2'b01,
    FLIT_BODY   = 2'b10,
    FLIT_TAIL   = 2'b11
  } flit_type_e;

  localparam int unsigned DIR_N    = 0;
  localparam int unsigned DIR_E    = 1;
  localparam int unsigned DIR_W    = 2;
  localparam int unsigned DIR_S    = 3;
  localparam int unsigned DIR_L    = 4;
  localparam int unsigned NUM_DIRS = 5;

  typedef logic [NUM_DIRS-1:0] dir_onehot_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ROUTED = 1'b1
  } route_state_e;

  function automatic dir_onehot_t dir_bit(input int unsigned d);
    return dir_onehot_t'(1) << d;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Circular flit buffer with push/pop, occupancy count and empty/full flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/router_input_channel.sv
// Router input port: RTS/DCTS receiver, flit FIFO, XY route decode and
// wormhole request hold. Optional parity check under ROUTER_PARITY_CHECK_EN.
module router_input_channel
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned CUR_X      = 0,
  parameter int unsigned CUR_Y      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  RTS,
  output logic                  DCTS,
  input  logic                  Grant_N,
  input  logic                  Grant_E,
  input  logic                  Grant_W,
  input  logic                  Grant_S,
  input  logic                  Grant_L,
  output logic                  Req_N,
  output logic                  Req_E,
  output logic                  Req_W,
  output logic                  Req_S,
  output logic                  Req_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] CX = ADDR_W'(CUR_X);
  localparam logic [ADDR_W-1:0] CY = ADDR_W'(CUR_Y);

  logic                  dcts_q;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] head;
  logic [1:0]            head_type;
  logic                  head_is_header;
  logic                  head_is_tail;
  logic [ADDR_W-1:0]     dest_x;
  logic [ADDR_W-1:0]     dest_y;
  route_state_e          state;
  dir_onehot_t           route_reg;
  dir_onehot_t           xy_dir;
  dir_onehot_t           grant_vec;
  dir_onehot_t           req_vec;

  assign DCTS = dcts_q;
  assign push = RTS & dcts_q & ~fifo_full;

  // Fullness is judged on the pre-pop count, so a same-cycle pop never frees a slot early.
  always_ff @(posedge clk) begin
    if (!rst) dcts_q <= 1'b0;
    else      dcts_q <= RTS & ~dcts_q & (count < CNT_W'(DEPTH));
  end

  router_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (RX),
    .dout (head),
    .count(count),
    .empty(empty),
    .full (fifo_full)
  );

  assign Data_out       = head;
  assign head_type      = head[DATA_WIDTH-1 -: 2];
  assign head_is_header = (head_type == FLIT_HEADER);
  assign head_is_tail   = (head_type == FLIT_TAIL);
  assign dest_x         = head[2*ADDR_W-1:ADDR_W];
  assign dest_y         = head[ADDR_W-1:0];

  always_comb begin
    xy_dir = dir_bit(DIR_L);
    if      (dest_x > CX) xy_dir = dir_bit(DIR_E);
    else if (dest_x < CX) xy_dir = dir_bit(DIR_W);
    else if (dest_y > CY) xy_dir = dir_bit(DIR_S);
    else if (dest_y < CY) xy_dir = dir_bit(DIR_N);
  end

  // Bit order of these vectors follows the DIR_* indices (N=0 .. L=4).
  assign grant_vec = {Grant_L, Grant_S, Grant_W, Grant_E, Grant_N};
  assign req_vec   = (state == ST_ROUTED && !empty) ? route_reg : '0;
  assign {Req_L, Req_S, Req_W, Req_E, Req_N} = req_vec;

  assign pop = (state == ST_ROUTED) & ~empty & (|(grant_vec & route_reg));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      route_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty && head_is_header) begin
            route_reg <= xy_dir;
            state     <= ST_ROUTED;
          end
        end
        ST_ROUTED: begin
          if (pop && head_is_tail) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst)              err_q <= 1'b0;
    else if (push && ^RX)  err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_input_channel.sv
// Bench for router_input_channel: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_router_input_channel;
  import router_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CX    = 1;
  localparam int CY    = 1;
`ifdef ROUTER_PARITY_CHECK_EN
  localparam logic [31:0] PAR_EN = 32'd1;
`else
  localparam logic [31:0] PAR_EN = 32'd0;
`endif

  localparam int K_DCTS  = 0;
  localparam int K_EMPTY = 1;
  localparam int K_REQ   = 2;
  localparam int K_ERR   = 3;
  localparam int K_DATA  = 4;
  localparam int K_VAL   = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] got;
    logic [31:0] exp;
  } lit_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] RX  = '0;
  logic          RTS = 1'b0;
  logic [4:0]    grant = '0;
  logic          DCTS;
  logic          Req_N, Req_E, Req_W, Req_S, Req_L;
  logic [DW-1:0] Data_out;
  logic          empty;
  logic          err;
  logic [4:0]    req;

  int   n_cmp = 0;
  int   n_fail = 0;
  bit   started = 1'b0;
  lit_t lits[$];

  logic [DW-1:0] mq[$];
  bit            m_dcts, m_routed, m_err;
  int unsigned   m_dir;

  always #5 clk = ~clk;

  router_input_channel #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_W    (AW),
    .CUR_X     (CX),
    .CUR_Y     (CY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .RTS     (RTS),
    .DCTS    (DCTS),
    .Grant_N (grant[0]),
    .Grant_E (grant[1]),
    .Grant_W (grant[2]),
    .Grant_S (grant[3]),
    .Grant_L (grant[4]),
    .Req_N   (Req_N),
    .Req_E   (Req_E),
    .Req_W   (Req_W),
    .Req_S   (Req_S),
    .Req_L   (Req_L),
    .Data_out(Data_out),
    .empty   (empty),
    .err     (err)
  );

  assign req = {Req_L, Req_S, Req_W, Req_E, Req_N};

  function automatic logic [1:0] ftype(input logic [DW-1:0] f);
    return f[DW-1:DW-2];
  endfunction

  function automatic int unsigned route_dir(input logic [DW-1:0] f);
    int x, y;
    x = int'(f[3:2]);
    y = int'(f[1:0]);
    if (x > CX) return DIR_E;
    if (x < CX) return DIR_W;
    if (y > CY) return DIR_S;
    if (y < CY) return DIR_N;
    return DIR_L;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [28:0] p);
    logic [DW-1:0] f;
    f = {t, 1'b0, p};
    if (^f) f[29] = 1'b1;
    return f;
  endfunction

  function automatic logic [DW-1:0] hdr(input int x, input int y, input int seed);
    return mk(FLIT_HEADER, {25'(seed), 2'(x), 2'(y)});
  endfunction

  function automatic logic [DW-1:0] body(input int seed);
    return mk(FLIT_BODY, 29'(seed));
  endfunction

  function automatic logic [DW-1:0] tail(input int seed);
    return mk(FLIT_TAIL, 29'(seed));
  endfunction

  // Reference model: FIFO as a queue, wormhole state as (routed, dir).
  always @(posedge clk) begin : model
    int            sz;
    bit            wr, pp;
    logic [DW-1:0] t;
    sz = mq.size();
    if (!rst) begin
      mq.delete();
      m_dcts   = 1'b0;
      m_routed = 1'b0;
      m_dir    = 0;
      m_err    = 1'b0;
    end else begin
      wr = RTS && m_dcts;
      pp = m_routed && sz > 0 && ((grant & dir_bit(m_dir)) != 5'b0);
      if (!m_routed && sz > 0 && ftype(mq[0]) == FLIT_HEADER) begin
        m_routed = 1'b1;
        m_dir    = route_dir(mq[0]);
      end else if (pp) begin
        t = mq.pop_front();
        if (ftype(t) == FLIT_TAIL) m_routed = 1'b0;
      end
      if (wr) begin
        mq.push_back(RX);
        if (PAR_EN != 0 && (^RX)) m_err = 1'b1;
      end
      m_dcts = RTS && !m_dcts && sz < DEPTH;
    end
  end

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endfunction

  always @(negedge clk) begin
    lit_t        l;
    logic [31:0] act;
    if (started) begin
      chk("dcts", 32'(DCTS), 32'(m_dcts));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("req", 32'(req), (m_routed && mq.size() > 0) ? 32'(dir_bit(m_dir)) : 32'd0);
      chk("err", 32'(err), 32'(m_err));
      if (mq.size() > 0) chk("data_out", Data_out, mq[0]);
      while (lits.size() > 0) begin
        l = lits.pop_front();
        case (l.kind)
          K_DCTS:  act = 32'(DCTS);
          K_EMPTY: act = 32'(empty);
          K_REQ:   act = 32'(req);
          K_ERR:   act = 32'(err);
          K_DATA:  act = Data_out;
          default: act = l.got;
        endcase
        chk(l.name, act, l.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string n, input int k, input logic [31:0] e, input logic [31:0] g);
    lit_t l;
    l.name = n;
    l.kind = k;
    l.got  = g;
    l.exp  = e;
    lits.push_back(l);
  endtask

  task automatic send(input logic [DW-1:0] f);
    bit ok;
    ok  = 1'b0;
    RTS = 1'b1;
    RX  = f;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (DCTS) ok = 1'b1;
    end
    if (!ok) lit("send_dcts_timeout", K_DCTS, 32'd1, 32'd0);
    else     tick();
    RTS = 1'b0;
  endtask

  task automatic drain(input string n, input int exp_pops);
    int  i;
    bit  done;
    i    = 0;
    done = 1'b0;
    while (i < 12 && !done) begin
      tick();
      i++;
      if (empty) done = 1'b1;
    end
    lit(n, K_VAL, 32'(exp_pops), 32'(i));
  endtask

  initial begin : stim
    logic [DW-1:0] fl[5];
    logic [DW-1:0] h, bad;
    int            pulses, last, minsp, idx;
    bit            prev, seen;
    int            dx[4], dy[4];
    int unsigned   dd[4];

    rst = 1'b0;
    tick();
    started = 1'b1;
    lit("rst_dcts", K_DCTS, 32'd0, 32'd0);
    lit("rst_empty", K_EMPTY, 32'd1, 32'd0);
    lit("rst_req", K_REQ, 32'd0, 32'd0);
    lit("rst_err", K_ERR, 32'd0, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Packet east: header (3,1), body, tail.
    h = hdr(3, 1, 16'h1A5);
    send(h);
    tick();
    lit("east_req", K_REQ, 32'b00010, 32'd0);
    send(body(32'h11));
    send(tail(32'h22));
    lit("east_head", K_DATA, h, 32'd0);
    grant[DIR_E] = 1'b1;
    drain("east_pops", 3);
    grant = '0;
    lit("east_req_off", K_REQ, 32'd0, 32'd0);
    lit("east_empty", K_EMPTY, 32'd1, 32'd0);

    dx = '{1, 1, 0, 1};
    dy = '{0, 2, 1, 1};
    dd = '{DIR_N, DIR_S, DIR_W, DIR_L};
    for (int k = 0; k < 4; k++) begin
      send(hdr(dx[k], dy[k], 40 + k));
      send(tail(50 + k));
      lit($sformatf("dest_req_%0d", k), K_REQ, 32'(dir_bit(dd[k])), 32'd0);
      grant = dir_bit(dd[k]);
      drain($sformatf("dest_pops_%0d", k), 2);
      grant = '0;
      lit($sformatf("dest_req_off_%0d", k), K_REQ, 32'd0, 32'd0);
    end

    // Back-pressure: RTS held with no grants.
    fl = '{hdr(3, 1, 7), body(1), body(2), body(3), tail(4)};
    idx = 0; prev = 1'b0; pulses = 0; last = -100; minsp = 99;
    RTS = 1'b1;
    RX  = fl[0];
    for (int c = 0; c < 16; c++) begin
      tick();
      if (prev && idx < 4) begin
        idx++;
        RX = fl[idx];
      end
      prev = DCTS;
      if (DCTS) begin
        pulses++;
        if (c - last < minsp) minsp = c - last;
        last = c;
      end
    end
    lit("full_pulses", K_VAL, 32'd4, 32'(pulses));
    lit("full_spacing", K_VAL, 32'd2, 32'(minsp));
    grant[DIR_W] = 1'b1;
    tick();
    grant = '0;
    lit("wrong_grant_head", K_DATA, fl[0], 32'd0);
    lit("wrong_grant_dcts", K_DCTS, 32'd0, 32'd0);
    grant[DIR_E] = 1'b1;
    tick();
    grant = '0;
    seen = 1'b0;
    for (int j = 0; j < 2 && !seen; j++) begin
      tick();
      if (DCTS) seen = 1'b1;
    end
    lit("fifth_dcts", K_VAL, 32'd1, 32'(seen));
    tick();
    RTS = 1'b0;
    grant[DIR_E] = 1'b1;
    drain("full_flush_pops", 4);
    grant = '1;
    tick();
    tick();
    grant = '0;
    lit("idle_grant_empty", K_EMPTY, 32'd1, 32'd0);
    lit("idle_grant_req", K_REQ, 32'd0, 32'd0);

    // Reset mid-packet with a handshake in flight.
    send(hdr(3, 1, 9));
    send(body(5));
    send(body(6));
    RTS = 1'b1;
    RX  = body(7);
    seen = 1'b0;
    for (int j = 0; j < 6 && !seen; j++) begin
      tick();
      if (DCTS) seen = 1'b1;
    end
    lit("pre_rst_dcts", K_VAL, 32'd1, 32'(seen));
    rst = 1'b0;
    tick();
    lit("mid_rst_empty", K_EMPTY, 32'd1, 32'd0);
    lit("mid_rst_dcts", K_DCTS, 32'd0, 32'd0);
    lit("mid_rst_req", K_REQ, 32'd0, 32'd0);
    rst = 1'b1;
    RTS = 1'b0;
    tick();
    send(hdr(1, 0, 12));
    send(tail(13));
    lit("post_rst_req", K_REQ, 32'b00001, 32'd0);
    grant[DIR_N] = 1'b1;
    drain("post_rst_pops", 2);
    grant = '0;

    // Header with a flipped parity bit.
    bad = hdr(3, 1, 21);
    bad[29] = ~bad[29];
    send(bad);
    lit("parity_err", K_ERR, PAR_EN, 32'd0);
    send(tail(22));
    grant[DIR_E] = 1'b1;
    drain("parity_pops", 2);
    grant = '0;
    lit("parity_err_sticky", K_ERR, PAR_EN, 32'd0);
    rst = 1'b0;
    tick();
    lit("parity_err_cleared", K_ERR, 32'd0, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
